// File: rtl/addr_decode_router_pkg.sv
// addr_decode_router_pkg: shared chip address schema, target classes and decoded-request type
// Also holds the decode_addr helper used by the router.
package addr_decode_router_pkg;
  localparam int ADDR_WIDTH = 27;
  localparam int OFFSET_WIDTH = 23;
  typedef enum logic [1:0] {ZAP_MEM, ZAP_CSR, NON_ZAP, RACK} tgt_class_e;
  typedef enum logic {ADDR_TYPE_MEM, ADDR_TYPE_CSR} addr_type_e;
  typedef logic [2:0] rack_id_t;
  typedef logic [2:0] rack_block_inst_id_t;
  typedef enum logic [2:0] {ZAP0, ZAP1, ZAP2, ZAP3, ZAP4, ZAP5, ZAP6, ZAP7} rack_zap_id_e;
  typedef enum logic [3:0] {
    ZBLK_RSVD0, ZBLK_CTRL, ZBLK_DMA, ZBLK_SCHED, ZBLK_L1, ZBLK_L2, ZBLK_MAC, ZBLK_VEC,
    ZBLK_SFU, ZBLK_NOC, ZBLK_TRACE, ZBLK_PMU, ZBLK_FUSE, ZBLK_RSVD13, ZBLK_RSVD14, ZBLK_RSVD15
  } zap_block_id_e;
  typedef enum logic [2:0] {
    NZ_SYS, NZ_DDR, NZ_PCIE, NZ_RSVD3, NZ_ETH, NZ_DBG, NZ_RACK_ID, NZ_MGMT
  } non_zap_block_id_e;
  typedef enum logic [1:0] {RBLK_ICE, RBLK_CRY, RBLK_PWR, RBLK_RSVD3} rack_block_id_e;
  typedef struct packed {
    logic         is_zap;
    addr_type_e   typ;
    rack_id_t     rack;
    rack_zap_id_e zap;
    logic [18:0]  offset;
  } zap_addr_t;
  typedef struct packed {
    logic          is_zap;
    addr_type_e    typ;
    rack_id_t      rack;
    rack_zap_id_e  zap;
    zap_block_id_e blk;
    logic [14:0]   offset;
  } zap_csr_addr_t;
  typedef struct packed {
    logic              is_zap;
    non_zap_block_id_e blk;
    logic [22:0]       offset;
  } non_zap_addr_t;
  typedef struct packed {
    logic                is_zap;
    non_zap_block_id_e   blk;
    rack_id_t            rack;
    rack_block_id_e      rblk;
    rack_block_inst_id_t inst;
    logic [14:0]         offset;
  } rack_addr_t;
  typedef union packed {
    zap_addr_t     zap;
    zap_csr_addr_t csr;
    non_zap_addr_t nz;
    rack_addr_t    rack;
  } addr_t;
  typedef struct packed {
    tgt_class_e              cls;
    logic [3:0]              blk;
    rack_id_t                rack;
    logic [2:0]              zap;
    rack_block_inst_id_t     inst;
    logic [OFFSET_WIDTH-1:0] offset;
    logic                    err;
  } dec_req_t;
  // Fields that do not exist for a class stay zero so the tgt outputs are zero-extended.
  function automatic dec_req_t decode_addr(addr_t a);
    dec_req_t d;
    d = '0;
    if (a.zap.is_zap) begin
      d.rack = a.zap.rack;
      d.zap = a.zap.zap;
      if (a.zap.typ == ADDR_TYPE_CSR) begin
        d.cls = ZAP_CSR;
        d.blk = a.csr.blk;
        d.offset = OFFSET_WIDTH'(a.csr.offset);
        d.err = a.csr.blk == ZBLK_RSVD0 || a.csr.blk > ZBLK_FUSE;
      end else begin
        d.cls = ZAP_MEM;
        d.offset = OFFSET_WIDTH'(a.zap.offset);
      end
    end else if (a.nz.blk == NZ_RACK_ID) begin
      d.cls = RACK;
      d.blk = 4'(a.rack.rblk);
      d.rack = a.rack.rack;
      d.inst = a.rack.inst;
      d.offset = OFFSET_WIDTH'(a.rack.offset);
      d.err = a.rack.rblk == RBLK_RSVD3 || (a.rack.rblk == RBLK_ICE && a.rack.inst != '0);
    end else begin
      d.cls = NON_ZAP;
      d.blk = 4'(a.nz.blk);
      d.offset = a.nz.offset;
      d.err = a.nz.blk == NZ_RSVD3;
    end
    return d;
  endfunction
endpackage

// File: rtl/addr_decode_router_if.sv
// addr_decode_router_if: upstream request/response and downstream target bus bundle
// slave: router view (accepts req, drives tgt, returns rsp); master: the surrounding bus/targets.
interface addr_decode_router_if #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 32
);
  logic                  req_vld;
  logic                  req_rdy;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_wr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  tgt_vld;
  logic                  tgt_rdy;
  logic [1:0]            tgt_class;
  logic [3:0]            tgt_blk;
  logic [2:0]            tgt_rack;
  logic [2:0]            tgt_zap;
  logic [2:0]            tgt_inst;
  logic [22:0]           tgt_offset;
  logic                  tgt_wr;
  logic [DATA_WIDTH-1:0] tgt_wdata;
  logic                  tgt_rsp_vld;
  logic                  tgt_rsp_rdy;
  logic [DATA_WIDTH-1:0] tgt_rsp_rdata;
  logic                  tgt_rsp_err;
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  modport slave (
    input  req_vld, req_addr, req_wr, req_wdata, tgt_rdy,
    input  tgt_rsp_vld, tgt_rsp_rdata, tgt_rsp_err, rsp_rdy,
    output req_rdy, tgt_vld, tgt_class, tgt_blk, tgt_rack, tgt_zap, tgt_inst, tgt_offset,
    output tgt_wr, tgt_wdata, tgt_rsp_rdy, rsp_vld, rsp_rdata, rsp_err
  );
  modport master (
    output req_vld, req_addr, req_wr, req_wdata, tgt_rdy,
    output tgt_rsp_vld, tgt_rsp_rdata, tgt_rsp_err, rsp_rdy,
    input  req_rdy, tgt_vld, tgt_class, tgt_blk, tgt_rack, tgt_zap, tgt_inst, tgt_offset,
    input  tgt_wr, tgt_wdata, tgt_rsp_rdy, rsp_vld, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/addr_decode_router_fifo.sv
// addr_order_fifo: DEPTH x 1-bit order FIFO, one bit per outstanding request (1 = local error)
// Ports: clk, rst (async, high), push/din, pop/dout (head), full, empty.
// Push while full is legal only together with a pop; the caller guarantees that.
module addr_order_fifo #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  assign dout = mem[rd_ptr];
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr == AW'(DEPTH - 1) ? '0 : wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr == AW'(DEPTH - 1) ? '0 : rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/addr_decode_router.sv
// addr_decode_router: decodes upstream requests into target classes/fields, errors unmapped ones locally, keeps responses in order
// Ports: clk, rst (async, high); bus (slave modport: req_*, tgt_*, tgt_rsp_*, rsp_*);
//        stray_rsp (sticky, response seen with nothing outstanding); dec_err_cnt (saturating local-error count).
module addr_decode_router #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUTST = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  addr_decode_router_if.slave  bus,
  output logic                 stray_rsp,
  output logic [15:0]          dec_err_cnt
);
  import addr_decode_router_pkg::*;
  dec_req_t dec;
  logic full, empty, head, pop, accept;
  assign dec = decode_addr(addr_t'(bus.req_addr[ADDR_WIDTH-1:0]));
  // Head bit picks the response source: 1 = answer locally, 0 = forward the target response.
  always_comb begin
    pop = !empty && bus.rsp_rdy && (head || bus.tgt_rsp_vld);
    bus.req_rdy = (!full || pop) && (dec.err || !bus.tgt_vld || bus.tgt_rdy);
    accept = bus.req_vld && bus.req_rdy;
    bus.rsp_vld = !empty && (head || bus.tgt_rsp_vld);
    bus.rsp_err = !empty && (head || bus.tgt_rsp_err);
    bus.rsp_rdata = (empty || head) ? {DATA_WIDTH{1'b0}} : bus.tgt_rsp_rdata;
    bus.tgt_rsp_rdy = !empty && !head && bus.rsp_rdy;
  end
  addr_order_fifo #(.DEPTH(MAX_OUTST)) u_order_fifo (
    .clk(clk),
    .rst(rst),
    .push(accept),
    .din(dec.err),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.tgt_vld <= 1'b0;
      bus.tgt_class <= '0;
      bus.tgt_blk <= '0;
      bus.tgt_rack <= '0;
      bus.tgt_zap <= '0;
      bus.tgt_inst <= '0;
      bus.tgt_offset <= '0;
      bus.tgt_wr <= 1'b0;
      bus.tgt_wdata <= '0;
    end else if (accept && !dec.err) begin
      bus.tgt_vld <= 1'b1;
      bus.tgt_class <= dec.cls;
      bus.tgt_blk <= dec.blk;
      bus.tgt_rack <= dec.rack;
      bus.tgt_zap <= dec.zap;
      bus.tgt_inst <= dec.inst;
      bus.tgt_offset <= dec.offset;
      bus.tgt_wr <= bus.req_wr;
      bus.tgt_wdata <= bus.req_wdata;
    end else if (bus.tgt_rdy) begin
      bus.tgt_vld <= 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stray_rsp <= 1'b0;
      dec_err_cnt <= '0;
    end else begin
      if (empty && bus.tgt_rsp_vld) stray_rsp <= 1'b1;
      if (accept && dec.err && dec_err_cnt != 16'hFFFF) dec_err_cnt <= dec_err_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_addr_decode_router.sv
// tb_addr_decode_router: directed + randomized bench with an address-arithmetic reference model and in-order scoreboard
module tb_addr_decode_router;
  localparam logic [31:0] MASK = 32'h5A5A_5A5A;
  typedef struct packed {
    logic err;
    logic [1:0] cls;
    logic [3:0] blk;
    logic [2:0] rack;
    logic [2:0] zap;
    logic [2:0] inst;
    logic [22:0] off;
  } ref_t;
  typedef struct packed {
    ref_t r;
    logic wr;
    logic [31:0] wdata;
  } exp_tgt_t;
  typedef struct {
    logic lerr;
    logic err;
    logic [31:0] data;
  } exp_rsp_t;
  typedef struct {
    logic [31:0] data;
    logic err;
    int when;
  } tgt_rsp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stray_rsp;
  logic [15:0] dec_err_cnt;
  always #5 clk = ~clk;
  addr_decode_router_if #(.ADDR_WIDTH(27), .DATA_WIDTH(32)) bus ();
  addr_decode_router #(.ADDR_WIDTH(27), .DATA_WIDTH(32), .MAX_OUTST(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .stray_rsp(stray_rsp),
    .dec_err_cnt(dec_err_cnt)
  );
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int exp_cnt = 0;
  int last_when = 0;
  int dly_lo = 0;
  int dly_hi = 0;
  logic exp_tgt_vld = 1'b0;
  logic exp_stray = 1'b0;
  logic force_stray = 1'b0;
  logic stalled = 1'b0;
  logic acc = 1'b0;
  logic [95:0] snap = '0;
  logic [32:0] last_rsp = '0;
  exp_rsp_t sb[$];
  exp_tgt_t eq[$];
  tgt_rsp_t tq[$];
  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  // Address schema rules computed with shifts and masks on the flat address.
  function automatic ref_t ref_dec(input logic [26:0] a);
    ref_t r;
    int v;
    int id;
    r = '0;
    v = int'(a);
    if (v >= (1 << 26)) begin
      r.rack = 3'((v >> 22) & 7);
      r.zap = 3'((v >> 19) & 7);
      if (((v >> 25) & 1) == 1) begin
        r.cls = 2'd1;
        r.blk = 4'((v >> 15) & 15);
        r.off = 23'(v & 'h7FFF);
        r.err = r.blk == 0 || r.blk >= 13;
      end else begin
        r.cls = 2'd0;
        r.off = 23'(v & 'h7FFFF);
      end
    end else begin
      id = (v >> 23) & 7;
      if (id == 6) begin
        r.cls = 2'd3;
        r.rack = 3'((v >> 20) & 7);
        r.blk = 4'((v >> 18) & 3);
        r.inst = 3'((v >> 15) & 7);
        r.off = 23'(v & 'h7FFF);
        r.err = r.blk == 3 || (r.blk == 0 && r.inst != 0);
      end else begin
        r.cls = 2'd2;
        r.blk = 4'(id);
        r.off = 23'(v & 'h7FFFFF);
        r.err = id == 3;
      end
    end
    return r;
  endfunction
  function automatic logic [95:0] tgt_fields();
    return {bus.tgt_class, bus.tgt_blk, bus.tgt_rack, bus.tgt_zap, bus.tgt_inst,
            bus.tgt_offset, bus.tgt_wr, bus.tgt_wdata};
  endfunction
  // One clock: called at a negedge with inputs set; checks, updates the model, returns at the next negedge.
  task automatic step();
    int n0;
    int w;
    logic hd;
    logic h_req, h_tgt, h_rsp, h_trsp, nxt_tgt;
    ref_t r;
    exp_tgt_t e;
    if (tq.size() > 0 && tq[0].when <= cyc) begin
      bus.tgt_rsp_vld = 1'b1;
      bus.tgt_rsp_rdata = tq[0].data;
      bus.tgt_rsp_err = tq[0].err;
    end else begin
      bus.tgt_rsp_vld = force_stray;
      bus.tgt_rsp_rdata = '0;
      bus.tgt_rsp_err = 1'b0;
    end
    #1;
    n0 = sb.size();
    hd = 1'b0;
    if (n0 > 0) hd = sb[0].lerr;
    h_req = bus.req_vld && bus.req_rdy;
    h_tgt = bus.tgt_vld && bus.tgt_rdy;
    h_rsp = bus.rsp_vld && bus.rsp_rdy;
    h_trsp = bus.tgt_rsp_vld && bus.tgt_rsp_rdy;
    chk("stray", stray_rsp, exp_stray);
    chk("err_cnt", dec_err_cnt, exp_cnt);
    chk("tgt_vld", bus.tgt_vld, exp_tgt_vld);
    if (stalled) chk("tgt_hold", tgt_fields(), snap);
    chk("rsp_vld", bus.rsp_vld, n0 > 0 && (hd || bus.tgt_rsp_vld));
    chk("tgt_rsp_rdy", bus.tgt_rsp_rdy, n0 > 0 && !hd && bus.rsp_rdy);
    if (h_rsp && n0 > 0) begin
      last_rsp = {bus.rsp_err, bus.rsp_rdata};
      chk("rsp", {bus.rsp_err, bus.rsp_rdata}, {sb[0].err, sb[0].data});
      void'(sb.pop_front());
    end
    if (h_trsp && tq.size() > 0) void'(tq.pop_front());
    if (h_tgt) begin
      if (eq.size() == 0) chk("tgt_unexpected", eq.size(), 1);
      else begin
        e = eq.pop_front();
        chk("tgt_fields", tgt_fields(), {e.r.cls, e.r.blk, e.r.rack, e.r.zap, e.r.inst, e.r.off, e.wr, e.wdata});
      end
      w = cyc + 1 + int'($urandom_range(dly_hi, dly_lo));
      if (w < last_when) w = last_when;
      last_when = w;
      tq.push_back('{bus.tgt_wdata ^ MASK, bus.tgt_wr & bus.tgt_wdata[0], w});
    end
    if (bus.req_vld)
      chk("req_rdy", bus.req_rdy, (n0 < 8 || h_rsp) && (ref_dec(bus.req_addr).err || !exp_tgt_vld || bus.tgt_rdy));
    nxt_tgt = exp_tgt_vld && !bus.tgt_rdy;
    if (h_req) begin
      r = ref_dec(bus.req_addr);
      sb.push_back('{r.err, r.err ? 1'b1 : (bus.req_wr & bus.req_wdata[0]), r.err ? 32'h0 : (bus.req_wdata ^ MASK)});
      if (r.err) begin
        if (exp_cnt < 65535) exp_cnt++;
      end else begin
        eq.push_back('{r, bus.req_wr, bus.req_wdata});
        nxt_tgt = 1'b1;
      end
    end
    if (n0 == 0 && bus.tgt_rsp_vld) exp_stray = 1'b1;
    stalled = bus.tgt_vld && !bus.tgt_rdy;
    snap = tgt_fields();
    acc = h_req;
    @(posedge clk);
    exp_tgt_vld = nxt_tgt;
    @(negedge clk);
    cyc++;
  endtask
  task automatic send(input logic [26:0] a, input logic wr, input logic [31:0] wd);
    bus.req_vld = 1'b1;
    bus.req_addr = a;
    bus.req_wr = wr;
    bus.req_wdata = wd;
    for (int i = 0; i < 100; i++) begin
      step();
      if (acc) break;
    end
    if (!acc) chk("send_timeout", acc, 1);
    bus.req_vld = 1'b0;
  endtask
  task automatic drain();
    bus.tgt_rdy = 1'b1;
    bus.rsp_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && tq.size() == 0 && !bus.tgt_vld) break;
      step();
    end
    chk("drain", sb.size(), 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.req_vld = 1'b0;
    bus.req_addr = '0;
    bus.req_wr = 1'b0;
    bus.req_wdata = '0;
    bus.tgt_rdy = 1'b0;
    bus.tgt_rsp_vld = 1'b0;
    bus.tgt_rsp_rdata = '0;
    bus.tgt_rsp_err = 1'b0;
    bus.rsp_rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tgt_vld", bus.tgt_vld, 0);
    chk("rst_rsp_vld", bus.rsp_vld, 0);
    chk("rst_tgt_data", tgt_fields(), 0);
    chk("rst_stray", stray_rsp, 0);
    chk("rst_cnt", dec_err_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    bus.tgt_rdy = 1'b1;
    bus.rsp_rdy = 1'b1;
    send(27'h6A98040, 1'b0, 32'h0000_CAFE ^ MASK);
    chk("csr_class", bus.tgt_class, 1);
    chk("csr_blk", bus.tgt_blk, 3);
    chk("csr_rack", bus.tgt_rack, 2);
    chk("csr_zap", bus.tgt_zap, 5);
    chk("csr_offset", bus.tgt_offset, 'h40);
    drain();
    chk("csr_rsp", last_rsp, {1'b0, 32'h0000_CAFE});
    send(27'h1800000, 1'b1, $urandom);
    chk("nz3_no_tgt", bus.tgt_vld, 0);
    chk("nz3_rsp", {bus.rsp_vld, bus.rsp_err, bus.rsp_rdata}, {2'b11, 32'h0});
    chk("nz3_cnt", dec_err_cnt, 1);
    drain();
    send(27'h3008000, 1'b0, $urandom);
    chk("ice_inst1_no_tgt", bus.tgt_vld, 0);
    chk("ice_inst1_err", {bus.rsp_vld, bus.rsp_err}, 2'b11);
    send(27'h3160010, 1'b0, $urandom);
    chk("rack_class", bus.tgt_class, 3);
    chk("rack_blk", bus.tgt_blk, 1);
    chk("rack_rack", bus.tgt_rack, 1);
    chk("rack_inst", bus.tgt_inst, 4);
    chk("rack_offset", bus.tgt_offset, 'h10);
    drain();
    dly_lo = 10;
    dly_hi = 10;
    send(27'h6A98040, 1'b1, 32'h1234_5678);
    send(27'h1800000, 1'b0, 32'h0);
    drain();
    chk("order_last_err", last_rsp, {1'b1, 32'h0});
    dly_lo = 0;
    dly_hi = 3;
    bus.tgt_rdy = 1'b0;
    bus.rsp_rdy = 1'b0;
    send(27'h4ABCDEF, 1'b1, 32'hA5A5_0001);
    for (int i = 0; i < 7; i++) send(27'h1800000 | 27'(i), 1'b0, 32'(i));
    bus.req_vld = 1'b1;
    bus.req_addr = 27'h1800007;
    repeat (3) step();
    chk("bp_blocked", acc, 0);
    chk("bp_req_rdy", bus.req_rdy, 0);
    chk("bp_tgt_vld", bus.tgt_vld, 1);
    bus.tgt_rdy = 1'b1;
    bus.rsp_rdy = 1'b1;
    send(27'h1800007, 1'b0, 32'h7);
    drain();
    force_stray = 1'b1;
    step();
    force_stray = 1'b0;
    repeat (3) step();
    chk("stray_sticky", stray_rsp, 1);
    dly_lo = 0;
    dly_hi = 4;
    for (int i = 0; i < 2000; i++) begin
      if (!bus.req_vld && $urandom_range(3, 0) != 0) begin
        bus.req_vld = 1'b1;
        bus.req_addr = 27'($urandom);
        bus.req_wr = 1'($urandom_range(1, 0));
        bus.req_wdata = $urandom;
      end
      bus.tgt_rdy = $urandom_range(3, 0) != 0;
      bus.rsp_rdy = $urandom_range(3, 0) != 0;
      step();
      if (acc) bus.req_vld = 1'b0;
    end
    bus.req_vld = 1'b0;
    drain();
    bus.tgt_rdy = 1'b0;
    bus.rsp_rdy = 1'b0;
    send(27'h6A98040, 1'b0, 32'h1);
    send(27'h1800000, 1'b0, 32'h2);
    rst = 1'b1;
    bus.tgt_rsp_vld = 1'b0;
    #2;
    chk("mid_rst_tgt_vld", bus.tgt_vld, 0);
    chk("mid_rst_rsp_vld", bus.rsp_vld, 0);
    chk("mid_rst_stray", stray_rsp, 0);
    chk("mid_rst_cnt", dec_err_cnt, 0);
    sb.delete();
    eq.delete();
    tq.delete();
    exp_tgt_vld = 1'b0;
    exp_stray = 1'b0;
    exp_cnt = 0;
    stalled = 1'b0;
    last_when = 0;
    #1;
    rst = 1'b0;
    @(negedge clk);
    bus.tgt_rdy = 1'b1;
    bus.rsp_rdy = 1'b1;
    send(27'h3160010, 1'b1, 32'hDEAD_BEE1);
    send(27'h3008000, 1'b0, 32'h0);
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
